maxpool_stream: RTL and testbench
=================================

// Module: maxpool_stream
// PURPOSE
//  Streaming 1-D max-pool stage that sits directly downstream of the conv_<LENX>_<LENF>_<W>_<P> engines.
//  Consumes the ReLU'd signed y stream through an AXI-style valid/ready handshake.
//  Emits max() of each non-overlapping POOL-sample window through a 2-entry output FIFO.
//  Tracks frame boundaries (FRAME = LENX-LENF+1 y-values per input vector) and flags the last pooled value of each frame.
// PARAMETERS
//  WIDTH  16  sample width, two's complement signed
//  FRAME  32  y-values per frame; must be a multiple of POOL (elaboration $error otherwise)
//  POOL   2   window length = stride; legal range 2..8
// PORTS
//  clk         in   1      rising-edge clock
//  reset       in   1      asynchronous, active-high reset
//  s_data_in   in   WIDTH  input sample (signed); sampled only when s_valid && s_ready
//  s_valid     in   1      upstream has a sample
//  s_ready     out  1      block can accept a sample this cycle
//  m_data_out  out  WIDTH  pooled sample (signed) at FIFO head
//  m_valid     out  1      FIFO non-empty
//  m_ready     in   1      downstream accepts m_data_out this cycle
//  m_last      out  1      head entry is the final pooled value of its frame
// BEHAVIOUR
//  Reset (async assert, sync to clk on deassert)
//   - Outputs: s_ready=0, m_valid=0, m_last=0, m_data_out=0.
//   - State: win_cnt=0, elem_cnt=0, FIFO empty; cur_max undefined but unused.
//   - s_ready rises the first clk edge after reset is low.
//  Input handshake
//   - s_ready = (fifo_cnt < 2); registered, so it does not depend on s_valid.
//   - Transfer occurs on an edge with s_valid && s_ready.
//   - No other input is sampled.
//  Window accumulation, per accepted sample x
//   - win_cnt==0: cur_max <= x.
//   - Otherwise: cur_max <= ($signed(x) > $signed(cur_max)) ? x : cur_max.
//   - Compare is full-width signed; ties keep the earlier value (results are identical).
//   - No saturation or width growth.
//   - win_cnt wraps POOL-1 -> 0; elem_cnt wraps FRAME-1 -> 0.
//   - On the accept where win_cnt==POOL-1, push max(cur_max, x) with last = (elem_cnt==FRAME-1).
//  Latency
//   - The completing sample is accepted on edge N; m_valid and the data are visible after edge N (one cycle).
//   - No combinational path from s_* to m_*.
//  Output FIFO (2 entries, registered)
//   - m_valid = fifo_cnt!=0; m_data_out and m_last are the head entry.
//   - Pop on m_valid && m_ready.
//   - Simultaneous push and pop keeps fifo_cnt unchanged; the new entry goes behind the head.
//   - fifo_cnt==2: s_ready=0 next cycle, so no push can hit a full FIFO.
//   - Pop from full restores s_ready on the following edge.
//   - m_data_out and m_last hold stable while m_valid && !m_ready.
//   - When empty, m_data_out holds its last value and m_last=0.
//  State machine (win_cnt doubles as the state)
//   - ACC0: first sample of a window.
//   - ACCn: intermediate samples.
//   - EMIT: last sample of a window, pushes to the FIFO.
//   - Transitions occur only on accepted samples; stalls are absorbed by holding the state.
//  Boundaries
//   - Frame wrap needs no gap; the next frame's first sample may arrive the cycle after the m_last-producing sample.
//   - Reset mid-window or mid-frame discards the partial window, pending FIFO entries and the frame position.
//   - m_ready asserted while empty: no effect.
//   - s_valid held while s_ready=0: data held by upstream, not consumed.
//  Throughput
//   - Sustains 1 input per cycle, and therefore 1 output per POOL cycles, when m_ready stays high.
// TESTING
//  1. POOL=2, inputs 5,-3,0x7FFF,0x7FFE, m_ready=1 -> outputs 5 then 0x7FFF, each 1 cycle after its 2nd input.
//  2. All-negative window 0x8000,0xFFFF -> 0xFFFF; mixed 0x8000,0x0000 -> 0x0000 (signed compare, not unsigned).
//  3. Continuous s_valid, m_ready=0 for 10 cycles -> 4 samples accepted, 2 entries queued, s_ready=0;
//     release m_ready -> pops in order, s_ready returns 1 cycle after the first pop.
//  4. FRAME=32, POOL=2, 64 ascending inputs 0..63 -> 32 outputs 1,3,..,63;
//     m_last=1 only on values 31 and 63.
//  5. Reset asserted after 1 sample of a window with 1 entry queued ->
//     m_valid=0 immediately (async), s_ready=0;
//     next window starting after reset produces its own max only.
//  6. Random s_valid/m_ready (50%) over 100 frames vs. reference model -> zero mismatches, no m_data_out change while stalled.

Source files
------------

// File: rtl/maxpool_stream.sv
// Streaming 1-D max-pool: reduces each non-overlapping POOL-sample window of a
// signed valid/ready stream to its maximum, queued through a 2-entry output FIFO.
module maxpool_stream #(
  parameter int WIDTH = 16,
  parameter int FRAME = 32,
  parameter int POOL  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] s_data_in,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [WIDTH-1:0] m_data_out,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last
);

  localparam int WIN_W  = $clog2(POOL);
  localparam int ELEM_W = $clog2(FRAME);
  localparam logic [WIN_W-1:0]  WIN_LAST  = WIN_W'(POOL - 1);
  localparam logic [ELEM_W-1:0] ELEM_LAST = ELEM_W'(FRAME - 1);

  generate
    if (FRAME % POOL != 0) begin : g_bad_frame
      $error("maxpool_stream: FRAME must be a multiple of POOL");
    end
    if (POOL < 2 || POOL > 8) begin : g_bad_pool
      $error("maxpool_stream: POOL must be in 2..8");
    end
  endgenerate

  typedef enum logic [1:0] {ACC0, ACCN, EMIT} state_t;

  state_t            state;
  logic [WIN_W-1:0]  win_cnt, win_cnt_nxt;
  logic [ELEM_W-1:0] elem_cnt, elem_cnt_nxt;
  logic [WIDTH-1:0]  cur_max, cur_max_nxt;
  logic              accept;
  logic              push;
  logic [WIDTH-1:0]  push_data;
  logic              push_last;
  logic              pop;
  logic [1:0]        fifo_cnt, fifo_cnt_nxt;
  logic [WIDTH-1:0]  head_data, tail_data;
  logic              head_last, tail_last;

  assign accept = s_valid && s_ready;
  assign pop    = m_valid && m_ready;

  // The window position is the state; decode it into the named phases.
  always_comb begin
    state = ACCN;
    if (win_cnt == '0) begin
      state = ACC0;
    end else if (win_cnt == WIN_LAST) begin
      state = EMIT;
    end
  end

  always_comb begin
    win_cnt_nxt  = win_cnt;
    elem_cnt_nxt = elem_cnt;
    cur_max_nxt  = cur_max;
    push         = 1'b0;
    push_data    = cur_max;
    push_last    = 1'b0;
    if (accept) begin
      if (state == ACC0 || $signed(s_data_in) > $signed(cur_max)) begin
        cur_max_nxt = s_data_in;
      end
      elem_cnt_nxt = (elem_cnt == ELEM_LAST) ? '0 : elem_cnt + 1'b1;
      case (state)
        EMIT: begin
          win_cnt_nxt = '0;
          push        = 1'b1;
          push_data   = cur_max_nxt;
          push_last   = (elem_cnt == ELEM_LAST);
        end
        default: win_cnt_nxt = win_cnt + 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_cnt  <= '0;
      elem_cnt <= '0;
      cur_max  <= '0;
    end else begin
      win_cnt  <= win_cnt_nxt;
      elem_cnt <= elem_cnt_nxt;
      cur_max  <= cur_max_nxt;
    end
  end

  always_comb begin
    fifo_cnt_nxt = fifo_cnt;
    if (push && !pop) begin
      fifo_cnt_nxt = fifo_cnt + 2'd1;
    end else if (pop && !push) begin
      fifo_cnt_nxt = fifo_cnt - 2'd1;
    end
  end

  // s_ready looks at the post-edge occupancy so a push can never land on a full FIFO.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fifo_cnt  <= 2'd0;
      s_ready   <= 1'b0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
    end else begin
      fifo_cnt <= fifo_cnt_nxt;
      s_ready  <= (fifo_cnt_nxt < 2'd2);
      if (pop && fifo_cnt == 2'd2) begin
        head_data <= tail_data;
        head_last <= tail_last;
      end
      if (push) begin
        if (fifo_cnt == 2'd0 || (fifo_cnt == 2'd1 && pop)) begin
          head_data <= push_data;
          head_last <= push_last;
        end else begin
          tail_data <= push_data;
          tail_last <= push_last;
        end
      end
    end
  end

  assign m_valid    = (fifo_cnt != 2'd0);
  assign m_data_out = head_data;
  assign m_last     = head_last && m_valid;

endmodule

// File: tb/tb_maxpool_stream.sv
// Self-checking bench for maxpool_stream: directed vectors, backpressure, frame,
// reset and randomized traffic compared against a queue-based max-pool model.
module tb_maxpool_stream;

  localparam int WIDTH = 16;
  localparam int FRAME = 32;
  localparam int POOL  = 2;
  localparam int OUTS_PER_FRAME = FRAME / POOL;

  logic             clk;
  logic             reset;
  logic [WIDTH-1:0] s_data_in;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] m_data_out;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] exp;
  } vec_t;

  vec_t vecs[6];

  maxpool_stream #(.WIDTH(WIDTH), .FRAME(FRAME), .POOL(POOL)) dut (
    .clk        (clk),
    .reset      (reset),
    .s_data_in  (s_data_in),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .m_data_out (m_data_out),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_last     (m_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Called at a negedge; returns at the next negedge after one active edge.
  task automatic applyStimulus(input logic v, input logic [WIDTH-1:0] d, input logic r);
    s_valid   = v;
    s_data_in = d;
    m_ready   = r;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic doReset();
    s_valid   = 1'b0;
    s_data_in = '0;
    m_ready   = 1'b0;
    reset     = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  function automatic logic [WIDTH-1:0] window_max(input int win[$]);
    int mx = win[0];
    foreach (win[i]) if (win[i] > mx) mx = win[i];
    return WIDTH'(mx);
  endfunction

  initial begin
    int accepted;
    int cyc;
    int out_cnt;
    int win[$];
    logic [WIDTH-1:0] exp_data[$];
    logic exp_last[$];
    logic hold, sv, mr, prev_stall, prev_l;
    logic [WIDTH-1:0] sd, prev_d;

    vecs[0] = '{16'h0005, 16'hFFFD, 16'h0005};
    vecs[1] = '{16'h7FFF, 16'h7FFE, 16'h7FFF};
    vecs[2] = '{16'h8000, 16'hFFFF, 16'hFFFF};
    vecs[3] = '{16'h8000, 16'h0000, 16'h0000};
    vecs[4] = '{16'h7FFF, 16'h8000, 16'h7FFF};
    vecs[5] = '{16'hFFFE, 16'hFFFE, 16'hFFFE};

    reset = 1'b1;
    s_valid = 1'b0; s_data_in = '0; m_ready = 1'b0;
    @(negedge clk);
    checkOutput("reset_s_ready", 32'(s_ready), 32'd0);
    checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("reset_m_last", 32'(m_last), 32'd0);
    checkOutput("reset_m_data", 32'(m_data_out), 32'd0);
    doReset();
    checkOutput("post_reset_s_ready_low", 32'(s_ready), 32'd0);
    applyStimulus(1'b0, '0, 1'b0);
    checkOutput("post_reset_s_ready_high", 32'(s_ready), 32'd1);

    // Directed windows: output must appear exactly one cycle after the 2nd sample.
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, vecs[i].a, 1'b1);
      checkOutput("vec_no_early_valid", 32'(m_valid), 32'd0);
      applyStimulus(1'b1, vecs[i].b, 1'b1);
      checkOutput("vec_valid", 32'(m_valid), 32'd1);
      checkOutput("vec_data", 32'(m_data_out), 32'(vecs[i].exp));
      checkOutput("vec_last", 32'(m_last), 32'd0);
    end
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("vec_drained", 32'(m_valid), 32'd0);

    // Backpressure: continuous s_valid with m_ready low for 10 cycles.
    doReset();
    applyStimulus(1'b0, '0, 1'b0);
    accepted = 0;
    for (int c = 0; c < 10; c++) begin
      if (s_ready) begin
        applyStimulus(1'b1, WIDTH'(10 * (accepted + 1)), 1'b0);
        accepted++;
      end else begin
        prev_d = m_data_out;
        applyStimulus(1'b1, WIDTH'(10 * (accepted + 1)), 1'b0);
        checkOutput("stall_hold", 32'(m_data_out), 32'(prev_d));
      end
    end
    checkOutput("bp_accepted", 32'(accepted), 32'd4);
    checkOutput("bp_s_ready", 32'(s_ready), 32'd0);
    checkOutput("bp_m_valid", 32'(m_valid), 32'd1);
    checkOutput("bp_head", 32'(m_data_out), 32'd20);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("bp_s_ready_back", 32'(s_ready), 32'd1);
    checkOutput("bp_second", 32'(m_data_out), 32'd40);
    checkOutput("bp_second_valid", 32'(m_valid), 32'd1);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("bp_empty", 32'(m_valid), 32'd0);
    checkOutput("bp_empty_last", 32'(m_last), 32'd0);
    checkOutput("bp_empty_hold", 32'(m_data_out), 32'd40);
    applyStimulus(1'b0, '0, 1'b1);
    checkOutput("bp_ready_when_empty", 32'(m_valid), 32'd0);

    // Two full frames of ascending data.
    doReset();
    applyStimulus(1'b0, '0, 1'b0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      checkOutput("frame_s_ready", 32'(s_ready), 32'd1);
      applyStimulus(1'b1, WIDTH'(i), 1'b1);
      if (i % POOL == POOL - 1) begin
        checkOutput("frame_valid", 32'(m_valid), 32'd1);
        checkOutput("frame_data", 32'(m_data_out), 32'(i));
        checkOutput("frame_last", 32'(m_last), 32'((i == FRAME - 1) || (i == 2 * FRAME - 1)));
      end
    end

    // Reset mid-window with an entry queued.
    doReset();
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'd100, 1'b0);
    applyStimulus(1'b1, 16'd200, 1'b0);
    applyStimulus(1'b1, 16'd300, 1'b0);
    checkOutput("mid_queued", 32'(m_data_out), 32'd200);
    s_valid = 1'b0;
    reset = 1'b1;
    #1;
    checkOutput("mid_reset_m_valid", 32'(m_valid), 32'd0);
    checkOutput("mid_reset_s_ready", 32'(s_ready), 32'd0);
    checkOutput("mid_reset_m_data", 32'(m_data_out), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b0, '0, 1'b0);
    applyStimulus(1'b1, 16'd5, 1'b1);
    checkOutput("mid_partial_discarded", 32'(m_valid), 32'd0);
    applyStimulus(1'b1, 16'd7, 1'b1);
    checkOutput("mid_new_valid", 32'(m_valid), 32'd1);
    checkOutput("mid_new_data", 32'(m_data_out), 32'd7);

    // Randomized traffic over 100 frames against the queue model.
    doReset();
    applyStimulus(1'b0, '0, 1'b0);
    accepted = 0; cyc = 0; out_cnt = 0;
    hold = 1'b0; sv = 1'b0; sd = '0; prev_stall = 1'b0; prev_d = '0; prev_l = 1'b0;
    while ((accepted < 100 * FRAME || exp_data.size() != 0) && cyc < 40000) begin
      checkOutput("rand_m_valid", 32'(m_valid), 32'(exp_data.size() != 0));
      if (prev_stall) begin
        checkOutput("rand_stall_data", 32'(m_data_out), 32'(prev_d));
        checkOutput("rand_stall_last", 32'(m_last), 32'(prev_l));
      end
      if (!hold) begin
        sv = (accepted < 100 * FRAME) ? 1'($urandom_range(0, 1)) : 1'b0;
        sd = WIDTH'($urandom);
      end
      mr = 1'($urandom_range(0, 1));
      if (m_valid && mr && exp_data.size() != 0) begin
        checkOutput("rand_data", 32'(m_data_out), 32'(exp_data.pop_front()));
        checkOutput("rand_last", 32'(m_last), 32'(exp_last.pop_front()));
      end
      if (sv && s_ready) begin
        accepted++;
        win.push_back(int'($signed(sd)));
        if (win.size() == POOL) begin
          exp_data.push_back(window_max(win));
          exp_last.push_back((out_cnt % OUTS_PER_FRAME) == OUTS_PER_FRAME - 1);
          out_cnt++;
          win.delete();
        end
      end
      hold = sv && !s_ready;
      prev_stall = m_valid && !mr;
      prev_d = m_data_out;
      prev_l = m_last;
      applyStimulus(sv, sd, mr);
      cyc++;
    end
    checkOutput("rand_accepted", 32'(accepted), 32'(100 * FRAME));
    checkOutput("rand_outputs", 32'(out_cnt), 32'(100 * OUTS_PER_FRAME));
    checkOutput("rand_drained", 32'(exp_data.size()), 32'd0);
    checkOutput("rand_final_valid", 32'(m_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
